// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU definitions for the hazard/stall controller: memory FSM states,
// default timeout and the register-hazard compare helper.
package hazard_stall_ctrl_pkg;

  localparam int REG_W           = 5;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

  // $0 is hard-wired to zero, so a load into it never creates a dependency.
  function automatic logic reg_hazard(input logic [REG_W-1:0] dst,
                                      input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Data-memory request/acknowledge handshake between the stall controller and memory.
interface hazard_stall_ctrl_if;
  logic mem_req_o;
  logic mem_ack_i;

  modport master (output mem_req_o, input mem_ack_i);
  modport slave  (input mem_req_o, output mem_ack_i);
endinterface

// File: rtl/hazard_detect.sv
// Purely combinational load-use comparator between the load in EX and the sources in ID.
module hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic             IDEX_memRead_i,
  input  logic [REG_W-1:0] IDEX_rt_i,
  input  logic [REG_W-1:0] IFID_rs_i,
  input  logic [REG_W-1:0] IFID_rt_i,
  output logic             load_use_o
);

  assign load_use_o = IDEX_memRead_i &
                      (reg_hazard(IDEX_rt_i, IFID_rs_i) | reg_hazard(IDEX_rt_i, IFID_rt_i));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and data-memory stall controller: memory handshake FSM with
// timeout, load-use hold, branch flush and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_stall_ctrl_if.master mem_if,
  input  logic                IDEX_memRead_i,
  input  logic [REG_W-1:0]    IDEX_rt_i,
  input  logic [REG_W-1:0]    IFID_rs_i,
  input  logic [REG_W-1:0]    IFID_rt_i,
  input  logic                branchTaken_i,
  input  logic                jump_i,
  input  logic                EXMEM_memRead_i,
  input  logic                EXMEM_memWrite_i,
  output logic                stall_o,
  output logic                stallHold_o,
  output logic                flush_o,
  output logic                pcWrite_o,
  output logic                IDEX_bubble_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    stallCount_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  mem_state_e       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             mem_access;
  logic             mem_req;
  logic             mem_stall;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .IDEX_memRead_i (IDEX_memRead_i),
    .IDEX_rt_i      (IDEX_rt_i),
    .IFID_rs_i      (IFID_rs_i),
    .IFID_rt_i      (IFID_rt_i),
    .load_use_o     (load_use)
  );

  assign mem_access = EXMEM_memRead_i | EXMEM_memWrite_i;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    mem_req   = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_access) begin
          mem_req   = 1'b1;
          mem_stall = 1'b1;
          tmo_d     = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // Releasing the stall on the ack cycle lets the pipeline advance on
        // that same edge, so the access is never re-requested.
        if (mem_if.mem_ack_i) begin
          state_d = IDLE;
        end else begin
          mem_req   = 1'b1;
          mem_stall = 1'b1;
          tmo_d     = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT)) state_d = ERR;
        end
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset gates the combinational handshake outputs so nothing leaks out
  // while the state is being forced back to IDLE.
  assign mem_if.mem_req_o = rst_i & mem_req;
  assign stall_o          = rst_i & mem_stall;
  assign stallHold_o      = load_use & ~stall_o;
  assign IDEX_bubble_o    = load_use & ~stall_o;
  assign flush_o          = (branchTaken_i | jump_i) & ~stall_o;
  assign pcWrite_o        = ~stall_o & ~stallHold_o;

  always_comb begin
    err_d = err_q | (state_d == ERR);
    cnt_d = cnt_q;
    if ((stall_o | stallHold_o) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err_o        = err_q;
  assign stallCount_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (TIMEOUT=8), with a
// narrow-counter second instance to observe stall-count saturation.
module tb_hazard_stall_ctrl;

  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        IDEX_memRead_i;
  logic [4:0]  IDEX_rt_i, IFID_rs_i, IFID_rt_i;
  logic        branchTaken_i, jump_i;
  logic        EXMEM_memRead_i, EXMEM_memWrite_i;
  logic        mem_ack;

  logic        stall, stallHold, flush, pcWrite, bubble, err;
  logic [15:0] stallCount;
  logic        stall2, stallHold2, flush2, pcWrite2, bubble2, err2;
  logic [2:0]  stallCount2;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl_if mem_if ();
  hazard_stall_ctrl_if mem_if2 ();
  assign mem_if.mem_ack_i  = mem_ack;
  assign mem_if2.mem_ack_i = mem_ack;

  hazard_stall_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_if(mem_if),
    .IDEX_memRead_i(IDEX_memRead_i), .IDEX_rt_i(IDEX_rt_i),
    .IFID_rs_i(IFID_rs_i), .IFID_rt_i(IFID_rt_i),
    .branchTaken_i(branchTaken_i), .jump_i(jump_i),
    .EXMEM_memRead_i(EXMEM_memRead_i), .EXMEM_memWrite_i(EXMEM_memWrite_i),
    .stall_o(stall), .stallHold_o(stallHold), .flush_o(flush),
    .pcWrite_o(pcWrite), .IDEX_bubble_o(bubble), .err_o(err),
    .stallCount_o(stallCount)
  );

  hazard_stall_ctrl #(.TIMEOUT(TMO), .CNT_W(3)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .mem_if(mem_if2),
    .IDEX_memRead_i(IDEX_memRead_i), .IDEX_rt_i(IDEX_rt_i),
    .IFID_rs_i(IFID_rs_i), .IFID_rt_i(IFID_rt_i),
    .branchTaken_i(branchTaken_i), .jump_i(jump_i),
    .EXMEM_memRead_i(EXMEM_memRead_i), .EXMEM_memWrite_i(EXMEM_memWrite_i),
    .stall_o(stall2), .stallHold_o(stallHold2), .flush_o(flush2),
    .pcWrite_o(pcWrite2), .IDEX_bubble_o(bubble2), .err_o(err2),
    .stallCount_o(stallCount2)
  );

  task automatic applyStimulus(input logic ex_rd, input logic [4:0] ex_rt,
                               input logic [4:0] id_rs, input logic [4:0] id_rt,
                               input logic br, input logic jmp,
                               input logic m_rd, input logic m_wr, input logic ack);
    IDEX_memRead_i   = ex_rd;
    IDEX_rt_i        = ex_rt;
    IFID_rs_i        = id_rs;
    IFID_rt_i        = id_rt;
    branchTaken_i    = br;
    jump_i           = jmp;
    EXMEM_memRead_i  = m_rd;
    EXMEM_memWrite_i = m_wr;
    mem_ack          = ack;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick;
    checkOutput("rst stall", 32'(stall), 0);
    checkOutput("rst mem_req", 32'(mem_if.mem_req_o), 0);
    checkOutput("rst err", 32'(err), 0);
    checkOutput("rst count", 32'(stallCount), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("rst gate mem_req", 32'(mem_if.mem_req_o), 0);
    checkOutput("rst gate stall", 32'(stall), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_i = 1'b1;
    tick;

    $display("[TB] register zero load");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0 hold", 32'(stallHold), 0);
    checkOutput("r0 pcWrite", 32'(pcWrite), 1);
    tick;
    checkOutput("r0 count", 32'(stallCount), 0);

    $display("[TB] load-use");
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("lu hold", 32'(stallHold), 1);
    checkOutput("lu bubble", 32'(bubble), 1);
    checkOutput("lu pcWrite", 32'(pcWrite), 0);
    checkOutput("lu flush", 32'(flush), 0);
    tick;
    checkOutput("lu count", 32'(stallCount), 1);
    applyStimulus(1, 7, 3, 7, 0, 0, 0, 0, 0);
    checkOutput("lu rt hold", 32'(stallHold), 1);
    tick;
    checkOutput("lu rt count", 32'(stallCount), 2);
    applyStimulus(0, 7, 7, 7, 0, 0, 0, 0, 0);
    checkOutput("no load hold", 32'(stallHold), 0);

    $display("[TB] branch and jump flush");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("br flush", 32'(flush), 1);
    checkOutput("br pcWrite", 32'(pcWrite), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("jmp flush", 32'(flush), 1);
    tick;
    checkOutput("br count", 32'(stallCount), 2);

    $display("[TB] memory handshake");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("hs req c%0d", i), 32'(mem_if.mem_req_o), 1);
      checkOutput($sformatf("hs stall c%0d", i), 32'(stall), 1);
      tick;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    checkOutput("hs ack req", 32'(mem_if.mem_req_o), 0);
    checkOutput("hs ack stall", 32'(stall), 0);
    checkOutput("hs ack pcWrite", 32'(pcWrite), 1);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hs idle req", 32'(mem_if.mem_req_o), 0);
    checkOutput("hs count", 32'(stallCount), 6);
    checkOutput("hs count narrow", 32'(stallCount2), 6);

    $display("[TB] memory stall dominates");
    applyStimulus(1, 5, 5, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dom flush c%0d", i), 32'(flush), 0);
      checkOutput($sformatf("dom hold c%0d", i), 32'(stallHold), 0);
      checkOutput($sformatf("dom bubble c%0d", i), 32'(bubble), 0);
      tick;
    end
    applyStimulus(1, 5, 5, 0, 1, 0, 1, 0, 1);
    checkOutput("dom ack flush", 32'(flush), 1);
    checkOutput("dom ack hold", 32'(stallHold), 1);
    checkOutput("dom ack pcWrite", 32'(pcWrite), 0);
    checkOutput("dom narrow flush", 32'(flush2), 1);
    checkOutput("dom narrow hold", 32'(stallHold2), 1);
    checkOutput("dom narrow bubble", 32'(bubble2), 1);
    checkOutput("dom narrow pcWrite", 32'(pcWrite2), 0);
    checkOutput("dom narrow req", 32'(mem_if2.mem_req_o), 0);
    checkOutput("dom narrow stall", 32'(stall2), 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dom count", 32'(stallCount), 9);

    $display("[TB] memory timeout");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("to first req", 32'(mem_if.mem_req_o), 1);
    tick;
    for (int i = 0; i < TMO; i++) begin
      checkOutput($sformatf("to wait stall c%0d", i), 32'(stall), 1);
      checkOutput($sformatf("to wait err c%0d", i), 32'(err), 0);
      tick;
    end
    checkOutput("to err", 32'(err), 1);
    checkOutput("to err stall", 32'(stall), 1);
    checkOutput("to err req", 32'(mem_if.mem_req_o), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tick;
    checkOutput("to ack ignored err", 32'(err), 1);
    checkOutput("to ack ignored stall", 32'(stall), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    checkOutput("to sticky stall", 32'(stall), 1);
    checkOutput("to count", 32'(stallCount), 20);
    checkOutput("to count saturated", 32'(stallCount2), 7);
    checkOutput("to narrow err", 32'(err2), 1);
    #1 rst_i = 1'b0;
    #1;
    checkOutput("to rst err", 32'(err), 0);
    checkOutput("to rst stall", 32'(stall), 0);
    checkOutput("to rst count", 32'(stallCount), 0);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("to idle stall", 32'(stall), 0);

    $display("[TB] reset mid-wait");
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick;
    tick;
    checkOutput("mid count", 32'(stallCount), 2);
    rst_i = 1'b0;
    #1;
    checkOutput("mid rst req", 32'(mem_if.mem_req_o), 0);
    checkOutput("mid rst count", 32'(stallCount), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("late ack req", 32'(mem_if.mem_req_o), 0);
    checkOutput("late ack stall", 32'(stall), 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("late ack count", 32'(stallCount), 0);
    checkOutput("late ack idle req", 32'(mem_if.mem_req_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
